// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared definitions for data-memory masters
// Contents: RV32I load/store funct3 codes, LSU state enum, byte-enable
// patterns and the request legality check used before a bus request.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    // An unsupported funct3 is folded into the misalignment fault so the
    // core sees a single fault flag for any request that never reaches the bus.
    function automatic logic lsu_fault(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
        logic bad_f3;
        logic mis;
        bad_f3 = we ? (f3 > F3_W) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        case (f3[1:0])
            2'd1:    mis = off[0];
            2'd2:    mis = (off != 2'd0);
            default: mis = 1'b0;
        endcase
        return bad_f3 | mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane extraction and sign/zero extension
// Ports: rdata (raw memory word), funct3 (load type), byte_off (byte address
// bits [1:0]) -> result (right-justified, extended load value). Combinational.
module load_extend
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (byte_off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store unit master for a word-organised data memory
// Core side: core_req/we/funct3/addr/wdata in; core_stall, core_done pulse,
// core_rdata, core_misaligned, core_bus_err out.
// Memory side: mem_req/we/addr/be/wdata out (registered, held until mem_gnt);
// mem_gnt, mem_rvalid, mem_rdata in.
module lsu_mem_master
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [2:0]        core_funct3,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_stall,
    output logic              core_done,
    output logic [31:0]       core_rdata,
    output logic              core_misaligned,
    output logic              core_bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    lsu_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       ext_data;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^core_addr[31:ADDR_W+2];

    load_extend u_load_extend (
        .rdata    (mem_rdata),
        .funct3   (f3_q),
        .byte_off (off_q),
        .result   (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        mis_d       = 1'b0;
        berr_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req) begin
                    if (lsu_fault(core_we, core_funct3, core_addr[1:0])) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d    = REQ;
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_we_d   = core_we;
                        mem_addr_d = core_addr[ADDR_W+1:2];
                        f3_d       = core_funct3;
                        off_d      = core_addr[1:0];
                        if (!core_we) begin
                            mem_be_d    = BE_ALL;
                            mem_wdata_d = 32'h0;
                        end else begin
                            case (core_funct3[1:0])
                                2'd0: begin
                                    mem_be_d    = BE_BYTE0 << core_addr[1:0];
                                    mem_wdata_d = {4{core_wdata[7:0]}};
                                end
                                2'd1: begin
                                    mem_be_d    = core_addr[1] ? BE_HI_HALF : BE_LO_HALF;
                                    mem_wdata_d = {2{core_wdata[15:0]}};
                                end
                                default: begin
                                    mem_be_d    = BE_ALL;
                                    mem_wdata_d = core_wdata;
                                end
                            endcase
                        end
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                // Grant beats a coincident timeout.
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    done_d    = 1'b1;
                    berr_d    = 1'b1;
                    rdata_d   = 32'h0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdata_d = ext_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= BE_NONE;
            mem_wdata_q <= 32'h0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            berr_q      <= berr_d;
            rdata_q     <= rdata_d;
        end
    end

    // Gated by rst so the stall drops the moment reset asserts, even while
    // the core is still holding core_req.
    assign core_stall = ~rst & ((state_q == IDLE && core_req) ||
                                state_q == REQ || state_q == WAIT);

    assign core_done       = done_q;
    assign core_rdata      = rdata_q;
    assign core_misaligned = mis_q;
    assign core_bus_err    = berr_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_be          = mem_be_q;
    assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed self-checking bench for lsu_mem_master
module tb_lsu_mem_master;

    localparam int ADDR_W = 10;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req, core_we;
    logic [2:0]        core_funct3;
    logic [31:0]       core_addr, core_wdata;
    logic              core_stall, core_done, core_misaligned, core_bus_err;
    logic [31:0]       core_rdata;
    logic              mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_done(core_done), .core_rdata(core_rdata),
        .core_misaligned(core_misaligned), .core_bus_err(core_bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_funct3 = 0; core_addr = 0; core_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        @(negedge clk); #1;
        checks++;
        if ({mem_req, mem_we, core_stall, core_done, core_misaligned, core_bus_err} !== 6'b0 ||
            core_rdata !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || mem_addr !== '0)
            begin errors++; $display("FAIL reset: req=%b stall=%b done=%b rdata=%h be=%b wdata=%h addr=%h, required all 0",
                mem_req, core_stall, core_done, core_rdata, mem_be, mem_wdata, mem_addr); end
        @(negedge clk); rst = 0;
        @(negedge clk);
    endtask

    task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int gnt_wait,
                            input logic [ADDR_W-1:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
        core_req = 1; core_we = 1; core_funct3 = f3; core_addr = addr; core_wdata = wd; mem_gnt = 0;
        #1; checks++;
        if (core_stall !== 1'b1 || mem_req !== 1'b0 || core_done !== 1'b0)
            begin errors++; $display("FAIL %s c0: stall=%b req=%b done=%b, required 1 0 0", name, core_stall, mem_req, core_done); end
        @(negedge clk);
        for (int i = 0; i <= gnt_wait; i++) begin
            mem_gnt = (i == gnt_wait);
            #1; checks++;
            if ({mem_req, mem_we, core_stall, core_done} !== 4'b1110 || mem_addr !== exp_addr ||
                mem_be !== exp_be || mem_wdata !== exp_wd)
                begin errors++; $display("FAIL %s req%0d: req=%b we=%b stall=%b done=%b addr=%h be=%b wdata=%h, required 1 1 1 0 %h %b %h",
                    name, i, mem_req, mem_we, core_stall, core_done, mem_addr, mem_be, mem_wdata, exp_addr, exp_be, exp_wd); end
            @(negedge clk);
        end
        mem_gnt = 0; core_req = 0;
        #1; checks++;
        if ({core_done, core_stall, mem_req, core_misaligned, core_bus_err} !== 5'b10000 || core_rdata !== 32'h0)
            begin errors++; $display("FAIL %s done: done=%b stall=%b req=%b mis=%b berr=%b rdata=%h, required 1 0 0 0 0 0",
                name, core_done, core_stall, mem_req, core_misaligned, core_bus_err, core_rdata); end
        @(negedge clk); #1; checks++;
        if (core_done !== 1'b0 || core_stall !== 1'b0)
            begin errors++; $display("FAIL %s post: done=%b stall=%b, required 0 0", name, core_done, core_stall); end
        @(negedge clk);
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp);
        core_req = 1; core_we = 0; core_funct3 = f3; core_addr = addr; core_wdata = 32'hFFFF_FFFF;
        #1; checks++;
        if (core_stall !== 1'b1 || mem_req !== 1'b0)
            begin errors++; $display("FAIL %s c0: stall=%b req=%b, required 1 0", name, core_stall, mem_req); end
        @(negedge clk); mem_gnt = 1;
        #1; checks++;
        if ({mem_req, mem_we} !== 2'b10 || mem_be !== 4'hF || mem_wdata !== 32'h0 || mem_addr !== addr[ADDR_W+1:2])
            begin errors++; $display("FAIL %s req: req=%b we=%b be=%b wdata=%h addr=%h, required 1 0 1111 0 %h",
                name, mem_req, mem_we, mem_be, mem_wdata, mem_addr, addr[ADDR_W+1:2]); end
        @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = rd;
        #1; checks++;
        if ({core_stall, core_done, mem_req} !== 3'b100)
            begin errors++; $display("FAIL %s wait: stall=%b done=%b req=%b, required 1 0 0", name, core_stall, core_done, mem_req); end
        @(negedge clk); mem_rvalid = 0; mem_rdata = 32'h5555_5555; core_req = 0;
        #1; checks++;
        if ({core_done, core_stall, core_misaligned, core_bus_err} !== 4'b1000 || core_rdata !== exp)
            begin errors++; $display("FAIL %s done: done=%b stall=%b mis=%b berr=%b rdata=%h, required 1 0 0 0 %h",
                name, core_done, core_stall, core_misaligned, core_bus_err, core_rdata, exp); end
        @(negedge clk); #1; checks++;
        if (core_done !== 1'b0 || core_rdata !== exp)
            begin errors++; $display("FAIL %s hold: done=%b rdata=%h, required 0 %h", name, core_done, core_rdata, exp); end
        @(negedge clk);
    endtask

    task automatic do_fault(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr);
        core_req = 1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = 32'h1234_5678;
        #1; checks++;
        if (core_stall !== 1'b1 || mem_req !== 1'b0 || core_done !== 1'b0)
            begin errors++; $display("FAIL %s c0: stall=%b req=%b done=%b, required 1 0 0", name, core_stall, mem_req, core_done); end
        @(negedge clk); core_req = 0;
        #1; checks++;
        if ({core_done, core_misaligned, core_bus_err, mem_req, core_stall} !== 5'b11000 || core_rdata !== 32'h0)
            begin errors++; $display("FAIL %s done: done=%b mis=%b berr=%b req=%b stall=%b rdata=%h, required 1 1 0 0 0 0",
                name, core_done, core_misaligned, core_bus_err, mem_req, core_stall, core_rdata); end
        @(negedge clk); #1; checks++;
        if (core_done !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL %s post: done=%b req=%b, required 0 0", name, core_done, mem_req); end
        @(negedge clk);
    endtask

    task automatic test_stores();
        do_store("sw_0x10", 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 10'd4, 4'b1111, 32'hDEAD_BEEF);
        do_store("sb_0x13", 3'd0, 32'h13, 32'h0000_00A5, 3, 10'd4, 4'b1000, 32'hA5A5_A5A5);
        do_store("sh_0x22", 3'd1, 32'h22, 32'hFFFF_1234, 1, 10'd8, 4'b1100, 32'h1234_1234);
        do_store("sb_0x01", 3'd0, 32'h01, 32'h0000_3C7E, 0, 10'd0, 4'b0010, 32'h7E7E_7E7E);
    endtask

    task automatic test_loads();
        do_load("lb_0x21",  3'd0, 32'h21, 32'h1234_F0AB, 32'hFFFF_FFF0);
        do_load("lbu_0x21", 3'd4, 32'h21, 32'h1234_F0AB, 32'h0000_00F0);
        do_load("lh_0x22",  3'd1, 32'h22, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu_0x22", 3'd5, 32'h22, 32'h8001_0000, 32'h0000_8001);
        do_load("lb_0x23",  3'd0, 32'h23, 32'h7F00_0080, 32'h0000_007F);
        do_load("lh_0x20",  3'd1, 32'h20, 32'h0000_7FFE, 32'h0000_7FFE);
        do_load("lw_0x24",  3'd2, 32'h24, 32'h89AB_CDEF, 32'h89AB_CDEF);
    endtask

    task automatic test_misaligned();
        do_fault("lw_0x06",   1'b0, 3'd2, 32'h06);
        do_fault("sh_0x05",   1'b1, 3'd1, 32'h05);
        do_fault("lhu_0x03",  1'b0, 3'd5, 32'h03);
        do_fault("sw_0x02",   1'b1, 3'd2, 32'h02);
        do_fault("ld_f3_3",   1'b0, 3'd3, 32'h00);
        do_fault("ld_f3_6",   1'b0, 3'd6, 32'h00);
        do_fault("st_f3_4",   1'b1, 3'd4, 32'h00);
    endtask

    // mode 0: rvalid on the last allowed cycle; 1: no rvalid; 2: no grant.
    task automatic do_timeout(input string name, input int mode);
        core_req = 1; core_we = 0; core_funct3 = 3'd2; core_addr = 32'h40;
        @(negedge clk);
        for (int c = 1; c <= TO; c++) begin
            mem_gnt    = (mode != 2) && (c == 1);
            mem_rvalid = (mode == 0) && (c == TO);
            mem_rdata  = 32'hCAFE_F00D;
            #1; checks++;
            if (core_stall !== 1'b1 || core_done !== 1'b0 || mem_req !== (mode == 2 || c == 1))
                begin errors++; $display("FAIL %s c%0d: stall=%b done=%b req=%b, required 1 0 %b",
                    name, c, core_stall, core_done, mem_req, (mode == 2 || c == 1)); end
            @(negedge clk);
        end
        mem_gnt = 0; mem_rvalid = 0; core_req = 0;
        #1; checks++;
        if (mode == 0) begin
            if ({core_done, core_bus_err, core_stall} !== 3'b100 || core_rdata !== 32'hCAFE_F00D)
                begin errors++; $display("FAIL %s done: done=%b berr=%b stall=%b rdata=%h, required 1 0 0 cafef00d",
                    name, core_done, core_bus_err, core_stall, core_rdata); end
        end else begin
            if ({core_done, core_bus_err, core_misaligned, core_stall, mem_req} !== 5'b11000 || core_rdata !== 32'h0)
                begin errors++; $display("FAIL %s done: done=%b berr=%b mis=%b stall=%b req=%b rdata=%h, required 1 1 0 0 0 0",
                    name, core_done, core_bus_err, core_misaligned, core_stall, mem_req, core_rdata); end
        end
        @(negedge clk); #1; checks++;
        if (core_done !== 1'b0 || core_bus_err !== 1'b0)
            begin errors++; $display("FAIL %s post: done=%b berr=%b, required 0 0", name, core_done, core_bus_err); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        do_timeout("to_rvalid_last", 0);
        do_timeout("to_wait", 1);
        do_timeout("to_req", 2);
    endtask

    // wait_phase 0: reset while mem_req is high; 1: reset in WAIT.
    task automatic do_reset_mid(input string name, input int wait_phase);
        core_req = 1; core_we = 0; core_funct3 = 3'd2; core_addr = 32'h30;
        @(negedge clk); mem_gnt = (wait_phase == 1);
        if (wait_phase == 1) begin @(negedge clk); mem_gnt = 0; end
        #1; checks++;
        if (core_stall !== 1'b1 || mem_req !== (wait_phase == 0))
            begin errors++; $display("FAIL %s pre: stall=%b req=%b, required 1 %b", name, core_stall, mem_req, (wait_phase == 0)); end
        rst = 1;
        #1; checks++;
        if ({mem_req, core_stall, core_done} !== 3'b000)
            begin errors++; $display("FAIL %s in_rst: req=%b stall=%b done=%b, required 0 0 0", name, mem_req, core_stall, core_done); end
        @(negedge clk); rst = 0; core_req = 0; mem_rvalid = 1;
        for (int c = 0; c < 3; c++) begin
            #1; checks++;
            if ({mem_req, core_stall, core_done} !== 3'b000)
                begin errors++; $display("FAIL %s after%0d: req=%b stall=%b done=%b, required 0 0 0", name, c, mem_req, core_stall, core_done); end
            @(negedge clk);
        end
        mem_rvalid = 0;
    endtask

    task automatic test_reset_mid();
        do_reset_mid("rst_req", 0);
        do_store("sw_after_rst", 3'd2, 32'h3FC, 32'h0BAD_F00D, 0, 10'hFF, 4'b1111, 32'h0BAD_F00D);
        do_reset_mid("rst_wait", 1);
        do_load("lb_after_rst", 3'd0, 32'h3FE, 32'h0080_0000, 32'hFFFF_FF80);
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit on the core side of the data-memory interface: the initiator that issues requests to a word-organised, byte-enabled data memory.
- Accepts one load or store per transaction from the execute stage.
- Steers store bytes onto lanes with byte enables, and extracts and sign/zero-extends load data.
- Detects misalignment and bus timeout, and stalls the core until the transaction completes.

Parameters:
- ADDR_W, 10, width of mem_addr (word address; memory depth 2^ADDR_W words).
- TIMEOUT_CYC, 16, maximum cycles spent in REQ plus WAIT before a bus error is reported; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- core_req  in  1  core requests a memory operation; held with operands stable while core_stall=1.
- core_we  in  1  1=store, 0=load.
- core_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- core_addr  in  32  byte address.
- core_wdata  in  32  store data, right-justified.
- core_stall  out  1  core must freeze.
- core_done  out  1  one-cycle completion pulse.
- core_rdata  out  32  extended load result, valid while core_done=1.
- core_misaligned  out  1  fault flag, valid with core_done.
- core_bus_err  out  1  timeout flag, valid with core_done.
- mem_req  out  1  request valid.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  word address = core_addr[ADDR_W+1:2].
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-steered write data.
- mem_gnt  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0, including mem_req, which drops immediately on reset assertion.
  - Timeout counter is 0.
  - A reset mid-transaction abandons it; no core_done is issued.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On core_req, check legality.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Illegal funct3: load funct3 ∈ {3,6,7}; store funct3 ≥ 3. Illegal funct3 is treated as misaligned.
  - Illegal request → DONE with core_misaligned=1; no mem_req is ever raised.
  - Legal request → latch mem_we/addr/be/wdata, funct3 and addr[1:0] into registers, then go to REQ.
- REQ:
  - mem_req=1 with registered fields held stable until mem_gnt.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - mem_rvalid is sampled only here, so the earliest sample is the cycle after gnt.
  - On mem_rvalid: register the extended load data into core_rdata, then go to DONE.
- DONE:
  - core_done=1 for exactly one cycle, with core_stall=0; return to IDLE.
  - core_req is ignored in DONE.
  - core_rdata holds its value until the next load completes; it is cleared to 0 on a store, fault or bus error completion.
- core_stall = (IDLE & core_req) | REQ | WAIT.
- Timeout:
  - Counter clears on leaving IDLE and increments each cycle in REQ or WAIT.
  - When count = TIMEOUT_CYC-1 without progress → DONE with core_bus_err=1.
  - mem_req drops on that transition.
  - If gnt or rvalid coincides with the timeout, the gnt/rvalid wins.
- Store steering:
  - SB: be=1<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
  - Loads drive be=4'b1111 and wdata=0.
- Load extraction:
  - Byte select from latched addr[1:0]; halfword select from addr[1].
  - funct3[2]=0 sign-extends; funct3[2]=1 zero-extends; LW passes the word through.
- Latency with gnt in the first REQ cycle and rvalid on the first WAIT cycle:
  - Store: core_done 2 cycles after core_req is seen.
  - Load: core_done 3 cycles after core_req is seen.
  - Fault: core_done 1 cycle after core_req is seen.

Decomposition:
- Package rv_mem_pkg:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State enum lsu_state_t {IDLE, REQ, WAIT, DONE}.
  - Byte-enable constants.
- Sub-module load_extend: combinational (rdata, funct3, byte_off) → 32-bit extended result; reusable by other memory masters.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, gnt immediate → mem_addr=4, be=1111, mem_wdata=0xDEADBEEF, core_done in cycle 2, stall high in cycles 0–1.
- SB addr=0x13 wdata=0x000000A5, gnt after 3 cycles → be=1000, wdata=0xA5A5A5A5, fields stable across all REQ cycles, done after gnt.
- LB/LBU addr=0x21 with rdata=0x1234F0AB on rvalid → core_rdata=0xFFFFFFF0 / 0x000000F0; LH addr=0x22 with rdata=0x8001_0000 → 0xFFFF8001.
- LW addr=0x06 → core_misaligned=1, core_done next cycle, mem_req never asserted; SH addr=0x05 → same.
- Load with gnt but no rvalid, TIMEOUT_CYC=16 → core_bus_err=1 with core_done after 16 REQ+WAIT cycles; rvalid arriving on the last cycle → normal completion, bus_err=0.
- rst asserted mid-WAIT → mem_req/core_stall/core_done go to 0 immediately; next core_req after release runs a clean transaction.
